// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches from imem, hands instructions to decode.
// Optional HLT detection is compiled in when IF_HALT_DETECT_EN is defined.
module if_fetch_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_data,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [15:0] inst,
    output logic [15:0] inst_pc,
    output logic [15:0] pc_plus2,
    output logic        halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] inst_q, inst_d;
    logic [15:0] inst_pc_q, inst_pc_d;
    logic [15:0] pc_plus2_q, pc_plus2_d;
    logic        halt_q, halt_d;
    logic        is_hlt;
    logic        hlt_op;

    assign hlt_op = (imem_data[15:12] == HALT_OPCODE);

`ifdef IF_HALT_DETECT_EN
    assign is_hlt = hlt_op;
    assign halted = (state_q == HALT);
`else
    assign is_hlt = 1'b0;
    assign halted = 1'b0;
    logic unused_hlt;
    assign unused_hlt = hlt_op;
`endif

    // Redirect targets are always halfword aligned; bit 0 is dropped.
    logic unused_rpc0;
    assign unused_rpc0 = redirect_pc[0];

    assign imem_req   = (state_q == FETCH);
    assign imem_addr  = pc_q;
    assign inst_valid = (state_q == HOLD);
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign pc_plus2   = pc_plus2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            inst_q     <= '0;
            inst_pc_q  <= '0;
            pc_plus2_q <= '0;
            halt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            pc_plus2_q <= pc_plus2_d;
            halt_q     <= halt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        pc_plus2_d = pc_plus2_q;
        halt_d     = halt_q;
        // Redirect overrides any same-cycle imem response or decode accept.
        if (redirect && (state_q != IDLE)) begin
            state_d = FETCH;
            pc_d    = {redirect_pc[15:1], 1'b0};
            halt_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = FETCH;
                FETCH: begin
                    if (imem_valid) begin
                        inst_d     = imem_data;
                        inst_pc_d  = pc_q;
                        pc_plus2_d = pc_q + 16'd2;
                        state_d    = HOLD;
                        if (is_hlt) halt_d = 1'b1;
                        else        pc_d   = pc_q + 16'd2;
                    end
                end
                HOLD: begin
                    if (inst_ready) state_d = halt_q ? HALT : FETCH;
                end
                HALT: state_d = HALT;
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; HLT expectations follow IF_HALT_DETECT_EN.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic [15:0] pc_plus2;
    logic        halted;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    if_fetch_stage #(.RESET_PC(16'h0000), .HALT_OPCODE(4'hF)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data(imem_data),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .pc_plus2(pc_plus2),
        .halted(halted)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; imem_valid = 1'b0; imem_data = '0;
        redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        #1;
        step();
        check("rst_req", {15'd0, imem_req}, 16'd0);
        check("rst_addr", imem_addr, 16'h0000);
        check("rst_ivalid", {15'd0, inst_valid}, 16'd0);
        check("rst_inst", inst, 16'h0000);
        check("rst_ipc", inst_pc, 16'h0000);
        check("rst_pp2", pc_plus2, 16'h0000);
        check("rst_halted", {15'd0, halted}, 16'd0);

        rst = 1'b0;
        step();
        check("first_req", {15'd0, imem_req}, 16'd1);
        check("first_addr", imem_addr, 16'h0000);

        // back-to-back, same-cycle response, decode always ready
        imem_valid = 1'b1; imem_data = 16'h1111; inst_ready = 1'b1;
        step();
        check("t1_ivalid", {15'd0, inst_valid}, 16'd1);
        check("t1_req_hold", {15'd0, imem_req}, 16'd0);
        check("t1_inst", inst, 16'h1111);
        check("t1_ipc", inst_pc, 16'h0000);
        check("t1_pp2", pc_plus2, 16'h0002);
        step();
        check("t1_addr2", imem_addr, 16'h0002);
        check("t1_req2", {15'd0, imem_req}, 16'd1);
        imem_data = 16'h2222;
        step();
        check("t1_ipc2", inst_pc, 16'h0002);
        check("t1_pp2b", pc_plus2, 16'h0004);
        step();
        check("t1_addr4", imem_addr, 16'h0004);

        // slow memory then decode stall
        imem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_req_wait", {15'd0, imem_req}, 16'd1);
            check("t2_addr_wait", imem_addr, 16'h0004);
        end
        imem_valid = 1'b1; imem_data = 16'h3333; inst_ready = 1'b0;
        step();
        imem_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t2_ivalid_stall", {15'd0, inst_valid}, 16'd1);
            check("t2_inst_stall", inst, 16'h3333);
            check("t2_req_stall", {15'd0, imem_req}, 16'd0);
            step();
        end
        check("t2_ivalid_last", {15'd0, inst_valid}, 16'd1);
        inst_ready = 1'b1;
        step();
        check("t2_addr6", imem_addr, 16'h0006);
        check("t2_ivalid_off", {15'd0, inst_valid}, 16'd0);

        // redirect with colliding response
        redirect = 1'b1; redirect_pc = 16'h1235; imem_valid = 1'b1; imem_data = 16'h4444;
        step();
        redirect = 1'b0;
        check("t3_addr", imem_addr, 16'h1234);
        check("t3_ivalid", {15'd0, inst_valid}, 16'd0);
        check("t3_req", {15'd0, imem_req}, 16'd1);
        imem_data = 16'h5555;
        step();
        check("t3_inst", inst, 16'h5555);
        check("t3_ipc", inst_pc, 16'h1234);
        step();
        check("t3_addr_next", imem_addr, 16'h1236);

        // PC wraparound
        redirect = 1'b1; redirect_pc = 16'hFFFE; imem_valid = 1'b0;
        step();
        redirect = 1'b0;
        check("t4_addr", imem_addr, 16'hFFFE);
        imem_valid = 1'b1; imem_data = 16'h6666;
        step();
        check("t4_ipc", inst_pc, 16'hFFFE);
        check("t4_pp2", pc_plus2, 16'h0000);
        step();
        check("t4_addr_wrap", imem_addr, 16'h0000);

        // HLT instruction
        imem_data = 16'hF000;
        step();
        check("t5_inst", inst, 16'hF000);
        check("t5_ipc", inst_pc, 16'h0000);
        imem_valid = 1'b0;
        step();
`ifdef IF_HALT_DETECT_EN
        check("t5_halted", {15'd0, halted}, 16'd1);
        check("t5_req", {15'd0, imem_req}, 16'd0);
        check("t5_ivalid", {15'd0, inst_valid}, 16'd0);
        step();
        check("t5_halted_stay", {15'd0, halted}, 16'd1);
        check("t5_req_stay", {15'd0, imem_req}, 16'd0);
`else
        check("t5_addr_next", imem_addr, 16'h0002);
        check("t5_req", {15'd0, imem_req}, 16'd1);
        check("t5_halted", {15'd0, halted}, 16'd0);
`endif
        redirect = 1'b1; redirect_pc = 16'h0040;
        step();
        redirect = 1'b0;
        check("t5_resume_addr", imem_addr, 16'h0040);
        check("t5_resume_req", {15'd0, imem_req}, 16'd1);
        check("t5_resume_halted", {15'd0, halted}, 16'd0);

        // reset during HOLD
        imem_valid = 1'b1; imem_data = 16'h7777; inst_ready = 1'b0;
        step();
        check("t6_ivalid", {15'd0, inst_valid}, 16'd1);
        rst = 1'b1; imem_valid = 1'b0;
        step();
        check("t6_ivalid_rst", {15'd0, inst_valid}, 16'd0);
        check("t6_req_rst", {15'd0, imem_req}, 16'd0);
        check("t6_addr_rst", imem_addr, 16'h0000);
        rst = 1'b0;
        step();
        check("t6_req_restart", {15'd0, imem_req}, 16'd1);
        check("t6_addr_restart", imem_addr, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
